i2s_tx_serializer: RTL and testbench

Serializes parallel stereo PCM samples onto the I2S data line, using the SCLK and LRCLK produced by the I2S clock generator. The block sits directly downstream of the clock generator and drives SDATA to the DAC/codec. It holds one stereo frame in a single-entry buffer and loads it at each left-channel start. On underrun it outputs a defined fill value.

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_edge_detect.sv | 29 ++
 rtl/i2s_tx_serializer.sv | 156 +++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: slot geometry, channel encoding and serializer FSM states.
package i2s_pkg;

    // SCLK periods per LRCLK half-period (one channel slot).
    localparam int unsigned BITS_PER_CH = 16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHIFT,
        PAD
    } state_e;

endpackage

// File: rtl/i2s_edge_detect.sv
// SCLK falling-edge and LRCLK any-edge detector. SCLK/LRCLK are generated from the
// same master clock, so a single register stage is enough (no synchronizer).
module i2s_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic lrclk_i,
    output logic sclk_fall_o,
    output logic lr_edge_o
);

    logic sclk_q;
    logic lrclk_q;

    // One-cycle delayed copies of the bit and word clocks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            sclk_q  <= sclk_i;
            lrclk_q <= lrclk_i;
        end
    end

    assign sclk_fall_o = sclk_q & ~sclk_i;
    assign lr_edge_o   = lrclk_q ^ lrclk_i;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: single-entry stereo buffer, loaded into the shifter at each
// left-channel start; SDATA is MSB-first with zero padding in unused slot bits.
// Build option I2S_TX_UNDERRUN_HOLD_EN: on underrun repeat the last frame instead of silence.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                MCLK,
    input  logic                RST,
    input  logic                SCLK,
    input  logic                LRCLK,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                SDATA,
    output logic                frame_start,
    output logic                underrun
);

    localparam int unsigned IdxW = $clog2(BITS_PER_CH + 1);

    logic sclk_fall;
    logic lr_edge;
    ch_e  ch;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_q, left_d;     // frame currently being transmitted
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                buf_full_q, buf_full_d;
    logic [SAMPLE_W-1:0] buf_left_q, buf_left_d;
    logic [SAMPLE_W-1:0] buf_right_q, buf_right_d;
    logic                sdata_q, sdata_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic                load;

    i2s_edge_detect u_edge_detect (
        .clk_i       (MCLK),
        .rst_i       (RST),
        .sclk_i      (SCLK),
        .lrclk_i     (LRCLK),
        .sclk_fall_o (sclk_fall),
        .lr_edge_o   (lr_edge)
    );

    assign ch   = ch_e'(LRCLK);
    assign load = lr_edge && (ch == CH_LEFT) && buf_full_q;

    // Next-state: channel (re)start on lr_edge has priority over a coincident SCLK fall.
    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        left_d        = left_q;
        right_d       = right_q;
        buf_full_d    = buf_full_q;
        buf_left_d    = buf_left_q;
        buf_right_d   = buf_right_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (lr_edge) begin
            state_d   = ARM;
            bit_idx_d = '0;
            if (ch == CH_LEFT) begin
                if (buf_full_q) begin
                    left_d        = buf_left_q;
                    right_d       = buf_right_q;
                    buf_full_d    = 1'b0;
                    frame_start_d = 1'b1;
                end else begin
                    underrun_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                    left_d  = left_q;
                    right_d = right_q;
`else
                    left_d  = '0;
                    right_d = '0;
`endif
                end
                shift_d = left_d;
            end else begin
                shift_d = right_q;
            end
        end else if (sclk_fall) begin
            unique case (state_q)
                IDLE: ;
                ARM: begin
                    sdata_d   = shift_q[SAMPLE_W-1];
                    shift_d   = shift_q << 1;
                    bit_idx_d = IdxW'(1);
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (bit_idx_q == IdxW'(SAMPLE_W)) begin
                        sdata_d = 1'b0;
                        state_d = PAD;
                    end else begin
                        sdata_d   = shift_q[SAMPLE_W-1];
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
                PAD: sdata_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end

        // A write coinciding with a load lands in the entry the load just freed.
        if (s_valid && (!buf_full_q || load)) begin
            buf_full_d  = 1'b1;
            buf_left_d  = s_left;
            buf_right_d = s_right;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            left_q        <= '0;
            right_q       <= '0;
            buf_full_q    <= 1'b0;
            buf_left_q    <= '0;
            buf_right_q   <= '0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            left_q        <= left_d;
            right_q       <= right_d;
            buf_full_q    <= buf_full_d;
            buf_left_q    <= buf_left_d;
            buf_right_q   <= buf_right_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign s_ready     = ~buf_full_q;
    assign SDATA       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a 16-bit and a 12-bit instance share the clocks.
module tb_i2s_tx_serializer;

    logic MCLK = 1'b0;
    logic RST = 1'b1;
    logic SCLK = 1'b1;
    logic LRCLK = 1'b0;
    logic [7:0] cnt = 8'd0;

    logic s_valid = 1'b0;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic s_ready, SDATA, frame_start, underrun;

    logic s_valid12 = 1'b0;
    logic [11:0] s_left12 = '0;
    logic [11:0] s_right12 = '0;
    logic s_ready12, sdata12, fs12, uf12;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int fs_cnt = 0, uf_cnt = 0, fs12_cnt = 0, uf12_cnt = 0;
    int fs_run = 0, uf_run = 0, fs_max = 0, uf_max = 0;
    int fs_times[$];

    i2s_tx_serializer #(.SAMPLE_W(16)) dut (
        .MCLK        (MCLK),
        .RST         (RST),
        .SCLK        (SCLK),
        .LRCLK       (LRCLK),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .SDATA       (SDATA),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    i2s_tx_serializer #(.SAMPLE_W(12)) dut12 (
        .MCLK        (MCLK),
        .RST         (RST),
        .SCLK        (SCLK),
        .LRCLK       (LRCLK),
        .s_valid     (s_valid12),
        .s_ready     (s_ready12),
        .s_left      (s_left12),
        .s_right     (s_right12),
        .SDATA       (sdata12),
        .frame_start (fs12),
        .underrun    (uf12)
    );

    initial forever #5 MCLK = ~MCLK;

    // Clock generator model: SCLK = MCLK/8, LRCLK = MCLK/256, LRCLK toggles on SCLK rise.
    initial forever begin
        @(posedge MCLK);
        #1;
        cnt = cnt + 8'd1;
        SCLK = ~cnt[2];
        LRCLK = cnt[7];
    end

    // Pulse monitor on the opposite MCLK edge.
    initial forever begin
        @(negedge MCLK);
        cyc++;
        if (frame_start) begin
            fs_cnt++;
            fs_times.push_back(cyc);
            fs_run++;
        end else fs_run = 0;
        if (underrun) begin
            uf_cnt++;
            uf_run++;
        end else uf_run = 0;
        if (fs_run > fs_max) fs_max = fs_run;
        if (uf_run > uf_max) uf_max = uf_run;
        if (fs12) fs12_cnt++;
        if (uf12) uf12_cnt++;
    end

    initial begin
        #300000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge MCLK);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("offer_timeout", 32'(s_ready), 32'd1);
        s_left = l;
        s_right = r;
        s_valid = 1'b1;
        @(negedge MCLK);
        s_valid = 1'b0;
    endtask

    // Samples SDATA at 32 SCLK rises: 16 left slot bits, then 16 right slot bits.
    task automatic capture_frame(input bit align, output logic [15:0] l, output logic [15:0] r,
                                 output logic [15:0] l12, output logic [15:0] r12);
        if (align) @(negedge LRCLK);
        for (int i = 0; i < 32; i++) begin
            @(posedge SCLK);
            if (i < 16) begin
                l[15-i] = SDATA;
                l12[15-i] = sdata12;
            end else begin
                r[31-i] = SDATA;
                r12[31-i] = sdata12;
            end
        end
    endtask

    logic [15:0] l, r, l12, r12;
    int fs0, uf0, n0, ones;
    bit found, prev_lr;

    initial begin
        // Reset state
        repeat (5) @(negedge MCLK);
        check_eq("rst_sdata", 32'(SDATA), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_frame_start", 32'(frame_start), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);

        // First frame after reset, both widths
        @(posedge LRCLK);
        repeat (4) @(negedge MCLK);
        RST = 1'b0;
        fs0 = fs_cnt;
        uf0 = uf_cnt;
        s_left12 = 12'h800;
        s_right12 = 12'h001;
        s_valid12 = 1'b1;
        offer(16'hA5C3, 16'h0F01);
        s_valid12 = 1'b0;
        check_eq("s_ready_drop", 32'(s_ready), 32'd0);
        capture_frame(1'b1, l, r, l12, r12);
        check_eq("f1_left", 32'(l), 32'h0000_A5C3);
        check_eq("f1_right", 32'(r), 32'h0000_0F01);
        check_eq("w12_left", 32'(l12), 32'h0000_8000);
        check_eq("w12_right", 32'(r12), 32'h0000_0010);
        check_eq("f1_fs_count", 32'(fs_cnt - fs0), 32'd1);
        check_eq("f1_uf_count", 32'(uf_cnt - uf0), 32'd0);
        check_eq("w12_fs_count", 32'(fs12_cnt), 32'd1);
        check_eq("w12_uf_count", 32'(uf12_cnt), 32'd0);
        check_eq("s_ready_back", 32'(s_ready), 32'd1);

        // Underrun: nothing offered
        fs0 = fs_cnt;
        uf0 = uf_cnt;
        capture_frame(1'b0, l, r, l12, r12);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        check_eq("ur_left", 32'(l), 32'h0000_A5C3);
        check_eq("ur_right", 32'(r), 32'h0000_0F01);
`else
        check_eq("ur_left", 32'(l), 32'h0000_0000);
        check_eq("ur_right", 32'(r), 32'h0000_0000);
`endif
        check_eq("ur_uf_count", 32'(uf_cnt - uf0), 32'd1);
        check_eq("ur_fs_count", 32'(fs_cnt - fs0), 32'd0);

        // Write in the same cycle as the load of a full buffer
        offer(16'h1234, 16'h8765);
        s_left = 16'hC001;
        s_right = 16'h00FF;
        s_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge MCLK);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        check_eq("sim_load_seen", 32'(found), 32'd1);
        check_eq("sim_s_ready_low", 32'(s_ready), 32'd0);
        capture_frame(1'b0, l, r, l12, r12);
        check_eq("sim_old_left", 32'(l), 32'h0000_1234);
        check_eq("sim_old_right", 32'(r), 32'h0000_8765);
        check_eq("sim_s_ready_held", 32'(s_ready), 32'd0);
        capture_frame(1'b0, l, r, l12, r12);
        check_eq("sim_new_left", 32'(l), 32'h0000_C001);
        check_eq("sim_new_right", 32'(r), 32'h0000_00FF);
        check_eq("sim_s_ready_free", 32'(s_ready), 32'd1);

        // Reset in the middle of a left word
        @(posedge LRCLK);
        offer(16'hFFFF, 16'hFFFF);
        @(negedge LRCLK);
        offer(16'h1111, 16'h2222);
        repeat (7) @(posedge SCLK);
        @(negedge MCLK);
        check_eq("pre_rst_sdata", 32'(SDATA), 32'd1);
        check_eq("pre_rst_s_ready", 32'(s_ready), 32'd0);
        RST = 1'b1;
        #1;
        check_eq("mid_rst_sdata", 32'(SDATA), 32'd0);
        check_eq("mid_rst_s_ready", 32'(s_ready), 32'd1);
        repeat (2) @(negedge MCLK);
        RST = 1'b0;
        offer(16'hFFFF, 16'h8001);
        ones = 0;
        prev_lr = LRCLK;
        for (int i = 0; i < 400; i++) begin
            @(negedge MCLK);
            if (SDATA) ones++;
            if (prev_lr && !LRCLK) break;
            prev_lr = LRCLK;
        end
        check_eq("post_rst_silent", 32'(ones), 32'd0);
        capture_frame(1'b0, l, r, l12, r12);
        check_eq("post_rst_left", 32'(l), 32'h0000_FFFF);
        check_eq("post_rst_right", 32'(r), 32'h0000_8001);

        // Back-to-back frames
        @(posedge LRCLK);
        fs0 = fs_cnt;
        uf0 = uf_cnt;
        n0 = fs_times.size();
        fork
            begin
                for (int k = 0; k < 4; k++) offer(16'h0001, 16'h8000);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    capture_frame(k == 0, l, r, l12, r12);
                    check_eq($sformatf("b2b_left%0d", k), 32'(l), 32'h0000_0001);
                    check_eq($sformatf("b2b_right%0d", k), 32'(r), 32'h0000_8000);
                end
            end
        join
        check_eq("b2b_fs_count", 32'(fs_cnt - fs0), 32'd4);
        check_eq("b2b_uf_count", 32'(uf_cnt - uf0), 32'd0);
        if (fs_times.size() >= n0 + 4) begin
            for (int k = 1; k < 4; k++)
                check_eq($sformatf("b2b_period%0d", k),
                         32'(fs_times[n0+k] - fs_times[n0+k-1]), 32'd256);
        end else begin
            check_eq("b2b_fs_recorded", 32'(fs_times.size() - n0), 32'd4);
        end
        check_eq("fs_width", 32'(fs_max), 32'd1);
        check_eq("uf_width", 32'(uf_max), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
